mem_fifo_ctrl_2000x509: RTL and testbench

- Single-clock FIFO controller that owns the write and read ports of a 2000x509 1R1W memory macro and turns them into a valid/ready stream FIFO.
- Upstream producers push 509-bit words. The block generates the active-low enables and addresses for the memory. It absorbs the macro's 1-cycle registered read latency through a 2-entry output buffer, so a downstream consumer with valid/ready backpressure sustains 1 word/cycle.
- Both memory clocks (wclk, rclk) are tied to this block's clk at the parent.

---
 rtl/mem_fifo_pkg.sv | 14 +
 rtl/mem_fifo_obuf.sv | 49 ++++
 rtl/mem_fifo_ctrl_2000x509.sv | 79 +++++++
 tb/tb_mem_fifo_ctrl_2000x509.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fifo_pkg.sv
// Shared sizing constants and pointer helper for the 2000x509 memory-backed FIFO.
package mem_fifo_pkg;

  localparam int DW    = 509;
  localparam int DEPTH = 2000;
  localparam int AW    = 11;
  localparam int CW    = 12;

  // Depth is not a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

endpackage

// File: rtl/mem_fifo_obuf.sv
// Two-entry in-order register FIFO that absorbs the memory read latency.
module mem_fifo_obuf
  import mem_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0 <= din;
          else               e1 <= din;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Pop implies at least one entry, so cnt_q is 1 or 2 here.
          if (cnt_q == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;
  assign cnt  = cnt_q;

endmodule

// File: rtl/mem_fifo_ctrl_2000x509.sv
// Valid/ready stream FIFO built around a 2000x509 1R1W macro with registered read.
module mem_fifo_ctrl_2000x509
  import mem_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] mem_waddr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_ren,
  input  logic [DW-1:0] mem_dout,
  output logic [CW-1:0] fill,
  output logic          empty
);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] mem_cnt;
  logic          inflight;
  logic [1:0]    ob_cnt;
  logic          push;
  logic          pop;
  logic          rd;
  logic [2:0]    credit;

  assign in_ready  = (mem_cnt != CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Words the output buffer will hold once the current read returns.
  assign credit    = 3'(ob_cnt) + 3'(inflight) - 3'(pop);
  assign rd        = (mem_cnt != '0) && (credit < 3'd2);

  assign mem_wen   = ~push;
  assign mem_waddr = wptr;
  assign mem_din   = in_data;
  assign mem_ren   = ~rd;
  assign mem_raddr = rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (rd)   rptr <= next_ptr(rptr);
      inflight <= rd;
      case ({push, rd})
        2'b10:   mem_cnt <= mem_cnt + CW'(1);
        2'b01:   mem_cnt <= mem_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  mem_fifo_obuf u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (mem_dout),
    .head (out_data),
    .cnt  (ob_cnt)
  );

  assign out_valid = (ob_cnt != 2'd0);
  assign fill      = mem_cnt + CW'(inflight) + CW'(ob_cnt);
  assign empty     = (fill == '0);

endmodule

// File: tb/tb_mem_fifo_ctrl_2000x509.sv
// Bench for mem_fifo_ctrl_2000x509: memory macro model, queue scoreboard, vectors and corner sequences.
module tb_mem_fifo_ctrl_2000x509;
  import mem_fifo_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] mem_waddr;
  logic          mem_wen;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_raddr;
  logic          mem_ren;
  logic [DW-1:0] mem_dout;
  logic [CW-1:0] fill;
  logic          empty;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int n_push = 0;
  bit wrap_hi = 1'b0;
  bit wrap_seen = 1'b0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] mem_model [DEPTH];

  always #5 clk = ~clk;

  mem_fifo_ctrl_2000x509 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .mem_din   (mem_din),
    .mem_raddr (mem_raddr),
    .mem_ren   (mem_ren),
    .mem_dout  (mem_dout),
    .fill      (fill),
    .empty     (empty)
  );

  // 1R1W macro with registered read; dout holds when not reading.
  always @(posedge clk) begin
    if (!mem_wen) mem_model[mem_waddr] <= mem_din;
    if (!mem_ren) mem_dout <= mem_model[mem_raddr];
  end

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w[DW-1:0];
  endfunction

  // Scoreboard: the FIFO contents are just a queue of accepted words.
  always @(negedge clk) begin
    if (mon_en) begin
      chk_i("conflict", int'(!mem_wen && !mem_ren && (mem_waddr == mem_raddr)), 0);
      chk_i("fill", int'(fill), q.size());
      chk_i("empty", int'(empty), int'(q.size() == 0));
      if (q.size() < DEPTH)     chk_i("in_ready_open", int'(in_ready), 1);
      if (q.size() == DEPTH + 2) chk_i("in_ready_full", int'(in_ready), 0);
      if (q.size() == 0)        chk_i("out_valid_idle", int'(out_valid), 0);
      if (!mem_wen && mem_waddr == AW'(DEPTH - 1)) wrap_hi = 1'b1;
      if (wrap_hi && !mem_wen && mem_waddr == '0) wrap_seen = 1'b1;
      if (rst) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk_i("pop_from_empty", 1, 0);
          else chk_d("order", out_data, q.pop_front());
        end
        if (in_valid && in_ready) begin
          q.push_back(in_data);
          n_push++;
        end
      end
    end
  end

  typedef struct {
    logic          iv;
    logic          ordy;
    logic [DW-1:0] din;
    logic          e_inr;
    logic          e_wen;
    logic          e_ren;
    logic [AW-1:0] e_waddr;
    logic [AW-1:0] e_raddr;
    logic          e_ov;
    logic [DW-1:0] e_od;
    int            e_fill;
  } vec_t;

  vec_t vt[5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int bound);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!done && n < bound) begin
      @(negedge clk);
      done = empty;
      cyc();
      n++;
    end
    chk_i(name, int'(done), 1);
  endtask

  initial begin
    int acc;
    bit pushing;
    bit seen;
    int n0;
    int cyc_n;
    logic [DW-1:0] base;
    logic [DW-1:0] first;

    vt[0] = '{1'b1, 1'b1, 509'h1AB, 1'b1, 1'b0, 1'b1, 11'd0, 11'd0, 1'b0, '0, 0};
    vt[1] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, '0, 1};
    vt[2] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b0, '0, 1};
    vt[3] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b1, 509'h1AB, 1};
    vt[4] = '{1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b1, 11'd0, 11'd0, 1'b0, '0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_i("rst_fill", int'(fill), 0);
    chk_i("rst_empty", int'(empty), 1);
    chk_i("rst_in_ready", int'(in_ready), 1);
    chk_i("rst_mem_wen", int'(mem_wen), 1);
    chk_i("rst_mem_ren", int'(mem_ren), 1);
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single word latency walk.
    for (int i = 0; i < 5; i++) begin
      in_valid = vt[i].iv; out_ready = vt[i].ordy; in_data = vt[i].din;
      @(negedge clk);
      chk_i($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vt[i].e_inr));
      chk_i($sformatf("v%0d_wen", i), int'(mem_wen), int'(vt[i].e_wen));
      chk_i($sformatf("v%0d_ren", i), int'(mem_ren), int'(vt[i].e_ren));
      if (!vt[i].e_wen) chk_i($sformatf("v%0d_waddr", i), int'(mem_waddr), int'(vt[i].e_waddr));
      if (!vt[i].e_ren) chk_i($sformatf("v%0d_raddr", i), int'(mem_raddr), int'(vt[i].e_raddr));
      chk_i($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vt[i].e_ov));
      if (vt[i].e_ov) chk_d($sformatf("v%0d_out_data", i), out_data, vt[i].e_od);
      chk_i($sformatf("v%0d_fill", i), int'(fill), vt[i].e_fill);
      cyc();
    end

    // Streaming: word k leaves in cycle k+3, fill settles at 3.
    base = 509'h1000;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data = base + DW'(k);
      @(negedge clk);
      if (k >= 3) begin
        chk_i("stream_valid", int'(out_valid), 1);
        chk_d("stream_data", out_data, base + DW'(k - 3));
        chk_i("stream_fill", int'(fill), 3);
      end
      cyc();
    end
    drain("stream_drain", 20);

    // Fill to capacity with output stalled, then drain in order.
    acc = 0;
    in_valid = 1'b1; out_ready = 1'b0; in_data = 509'h5000;
    repeat (2010) begin
      @(negedge clk);
      pushing = in_ready;
      if (pushing) acc++;
      cyc();
      if (pushing) in_data = in_data + DW'(1);
    end
    in_valid = 1'b0;
    chk_i("full_accepted", acc, DEPTH + 2);
    @(negedge clk);
    chk_i("full_in_ready", int'(in_ready), 0);
    chk_i("full_fill", int'(fill), DEPTH + 2);
    cyc();
    drain("full_drain", 2200);

    // Random stalls across pointer wrap.
    n0 = n_push;
    cyc_n = 0;
    while ((n_push - n0) < 5000 && cyc_n < 40000) begin
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      in_data   = rand_word();
      cyc();
      cyc_n++;
    end
    chk_i("rand_pushed", n_push - n0, 5000);
    drain("rand_drain", 6000);
    chk_i("rand_wrap_seen", int'(wrap_seen), 1);

    // Reset landing while a read is in flight.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_data = 509'h7000 + DW'(k);
      cyc();
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = !mem_ren;
      cyc();
    end
    chk_i("midrst_read_issued", int'(seen), 1);
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_i("midrst_out_valid", int'(out_valid), 0);
    chk_i("midrst_fill", int'(fill), 0);
    cyc();
    first = rand_word();
    in_valid = 1'b1; in_data = first;
    cyc();
    in_valid = 1'b0; in_data = rand_word(); out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk_d("midrst_first_out", out_data, first);
      end
      cyc();
    end
    chk_i("midrst_out_seen", int'(seen), 1);
    drain("midrst_drain", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
